// File: rtl/button_event_scheduler.sv
// Turns debounced button levels into PRESS/RELEASE/LONG/REPEAT events and arbitrates them
// round-robin onto a single valid/ready event port, with an ms timebase for hold timing.
module button_event_scheduler #(
  parameter int unsigned N_BUTTONS     = 4,
  parameter int unsigned CLK_FREQ      = 50_000_000,
  parameter int unsigned LONG_PRESS_MS = 1000,
  parameter int unsigned REPEAT_MS     = 200,
  localparam int unsigned ID_W         = (N_BUTTONS > 1) ? $clog2(N_BUTTONS) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_BUTTONS-1:0] btn_level,
  input  logic                 enable,
  output logic                 evt_valid,
  input  logic                 evt_ready,
  output logic [ID_W-1:0]      evt_id,
  output logic [1:0]           evt_type,
  output logic                 overflow
);

  localparam int unsigned TickDiv = (CLK_FREQ / 1000 > 1) ? CLK_FREQ / 1000 : 1;
  localparam int unsigned PreW    = (TickDiv > 1) ? $clog2(TickDiv) : 1;
  localparam int unsigned CntMax  = (LONG_PRESS_MS > REPEAT_MS) ? LONG_PRESS_MS : REPEAT_MS;
  localparam int unsigned CntW    = $clog2(CntMax + 1);

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StPressed = 2'd1;
  localparam logic [1:0] StHeld    = 2'd2;

  localparam logic [1:0] EvPress   = 2'b00;
  localparam logic [1:0] EvRelease = 2'b01;
  localparam logic [1:0] EvLong    = 2'b10;
  localparam logic [1:0] EvRepeat  = 2'b11;

  logic [PreW-1:0]      pre_q;
  logic                 ms_tick;
  logic [N_BUTTONS-1:0] lvl_q, prev_q, rise;
  logic [1:0]           st_q [N_BUTTONS];
  logic [1:0]           st_d [N_BUTTONS];
  logic [CntW-1:0]      cnt_q [N_BUTTONS];
  logic [CntW-1:0]      cnt_d [N_BUTTONS];
  logic [CntW-1:0]      cnt_inc [N_BUTTONS];
  logic [N_BUTTONS-1:0] post_v;
  logic [1:0]           post_t [N_BUTTONS];
  logic [N_BUTTONS-1:0] slot_v_q, slot_v_d, drain;
  logic [1:0]           slot_t_q [N_BUTTONS];
  logic [1:0]           slot_t_d [N_BUTTONS];
  logic                 ovf_q, ovf_d;
  logic                 evt_valid_q, load, found;
  logic [ID_W-1:0]      evt_id_q, rr_q, rr_next, win_id;
  logic [1:0]           evt_type_q, win_type;
  int unsigned          win_idx;

  assign ms_tick = (pre_q == PreW'(TickDiv - 1));
  // Level is registered once more so a rise sampled at edge t posts its slot at t+1.
  assign rise    = lvl_q & ~prev_q;
  assign load    = ~evt_valid_q | evt_ready;

  always_comb begin
    for (int unsigned i = 0; i < N_BUTTONS; i++) begin
      st_d[i]    = st_q[i];
      cnt_d[i]   = cnt_q[i];
      post_v[i]  = 1'b0;
      post_t[i]  = EvPress;
      cnt_inc[i] = (cnt_q[i] == CntW'(CntMax)) ? cnt_q[i] : cnt_q[i] + CntW'(1);
      if (!enable) begin
        st_d[i]  = StIdle;
        cnt_d[i] = '0;
      end else begin
        case (st_q[i])
          StIdle: begin
            if (rise[i]) begin
              st_d[i]   = StPressed;
              cnt_d[i]  = '0;
              post_v[i] = 1'b1;
              post_t[i] = EvPress;
            end
          end
          StPressed, StHeld: begin
            if (!lvl_q[i]) begin
              st_d[i]   = StIdle;
              cnt_d[i]  = '0;
              post_v[i] = 1'b1;
              post_t[i] = EvRelease;
            end else if (ms_tick) begin
              if ((st_q[i] == StPressed) && (cnt_inc[i] >= CntW'(LONG_PRESS_MS))) begin
                st_d[i]   = StHeld;
                cnt_d[i]  = '0;
                post_v[i] = 1'b1;
                post_t[i] = EvLong;
              end else if ((st_q[i] == StHeld) && (cnt_inc[i] >= CntW'(REPEAT_MS))) begin
                cnt_d[i]  = '0;
                post_v[i] = 1'b1;
                post_t[i] = EvRepeat;
              end else begin
                cnt_d[i] = cnt_inc[i];
              end
            end
          end
          default: begin
            st_d[i]  = StIdle;
            cnt_d[i] = '0;
          end
        endcase
      end
    end
  end

  // Round-robin search: first valid slot at or after rr_q, wrapping.
  always_comb begin
    found    = 1'b0;
    win_idx  = 0;
    win_type = EvPress;
    for (int unsigned k = 0; k < N_BUTTONS; k++) begin
      for (int unsigned i = 0; i < N_BUTTONS; i++) begin
        if (!found && slot_v_q[i] && (i == (32'(rr_q) + k) % N_BUTTONS)) begin
          found    = 1'b1;
          win_idx  = i;
          win_type = slot_t_q[i];
        end
      end
    end
    win_id  = ID_W'(win_idx);
    rr_next = (win_idx + 1 == N_BUTTONS) ? '0 : ID_W'(win_idx + 1);
  end

  always_comb begin
    ovf_d = ovf_q;
    for (int unsigned i = 0; i < N_BUTTONS; i++) begin
      drain[i]    = load & found & (win_idx == i);
      slot_v_d[i] = slot_v_q[i] & ~drain[i];
      slot_t_d[i] = slot_t_q[i];
      if (post_v[i]) begin
        if (!slot_v_q[i] || drain[i]) begin
          slot_v_d[i] = 1'b1;
          slot_t_d[i] = post_t[i];
        end else begin
          ovf_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q       <= '0;
      lvl_q       <= '0;
      prev_q      <= '0;
      slot_v_q    <= '0;
      ovf_q       <= 1'b0;
      evt_valid_q <= 1'b0;
      evt_id_q    <= '0;
      evt_type_q  <= '0;
      rr_q        <= '0;
      for (int unsigned i = 0; i < N_BUTTONS; i++) begin
        st_q[i]     <= StIdle;
        cnt_q[i]    <= '0;
        slot_t_q[i] <= '0;
      end
    end else begin
      pre_q    <= ms_tick ? '0 : pre_q + PreW'(1);
      lvl_q    <= btn_level;
      prev_q   <= lvl_q;
      slot_v_q <= slot_v_d;
      ovf_q    <= ovf_d;
      for (int unsigned i = 0; i < N_BUTTONS; i++) begin
        st_q[i]     <= st_d[i];
        cnt_q[i]    <= cnt_d[i];
        slot_t_q[i] <= slot_t_d[i];
      end
      if (load) begin
        evt_valid_q <= found;
        if (found) begin
          evt_id_q   <= win_id;
          evt_type_q <= win_type;
          rr_q       <= rr_next;
        end
      end
    end
  end

  assign evt_valid = evt_valid_q;
  assign evt_id    = evt_id_q;
  assign evt_type  = evt_type_q;
  assign overflow  = ovf_q;

endmodule
